// File: rtl/moesi_pkg.sv
// moesi_pkg: bus encodings, sequencer states and error bit positions
// shared by the coherency sequencer and its watchdog.
package moesi_pkg;

    typedef enum logic [1:0] {
        BUS_WB   = 2'b00,
        BUS_RD   = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_UPGR = 2'b11
    } bus_type_e;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SNOOP      = 3'd1,
        S_MEM_REQ    = 3'd2,
        S_MEM_RESP   = 3'd3,
        S_CACHE_DATA = 3'd4,
        S_MEM_WR     = 3'd5,
        S_FILL       = 3'd6
    } seq_state_e;

    localparam int ERR_BUSY        = 0;
    localparam int ERR_MULTI_OWNER = 1;
    localparam int ERR_TIMEOUT     = 2;
    localparam int ERR_W           = 3;

endpackage

// File: rtl/coh_seq_watchdog.sv
// coh_seq_watchdog: counts cycles spent in one waiting state.
// Only built when COH_SEQ_TIMEOUT_EN is defined.
`ifdef COH_SEQ_TIMEOUT_EN
module coh_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt;

    // clear marks the first cycle of a new state, so it counts as zero
    assign w_cnt  = clear ? '0 : r_cnt;
    assign expire = enable && (w_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/coherency_mem_sequencer.sv
// coherency_mem_sequencer: runs one snoop-bus transaction at a time against
// snoopers and memory. Optional watchdog: define COH_SEQ_TIMEOUT_EN.
module coherency_mem_sequencer
    import moesi_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int LINE_BYTES     = 64,
    parameter int DATA_WIDTH     = LINE_BYTES * 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_valid,
    input  logic [1:0]            bus_type,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [1:0]            granted_core_id,
    input  logic [NUM_CORES-1:0]  snoop_hit,
    input  logic [NUM_CORES-1:0]  snoop_owner,
    input  logic                  snoop_data_valid,
    input  logic [DATA_WIDTH-1:0] snoop_data,
    output logic                  seq_busy,
    output logic                  mem_req_valid,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output logic                  fill_valid,
    output logic [1:0]            fill_core_id,
    output logic [1:0]            fill_type,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_shared,
    output logic [2:0]            err_status,
    input  logic                  err_clr
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~(ADDR_WIDTH'(LINE_BYTES - 1));

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    seq_state_e            r_state;
    bus_type_e             r_type;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_core;
    logic                  r_busy;
    logic                  r_mem_valid;
    logic                  r_mem_wr;
    logic                  r_fill_valid;
    logic [DATA_WIDTH-1:0] r_fill_data;
    logic                  r_shared;
    logic [ERR_W-1:0]      r_err;

    logic [NUM_CORES-1:0]  w_mask;
    logic [NUM_CORES-1:0]  w_hit;
    logic [NUM_CORES-1:0]  w_own;
    logic                  w_is_upgr;
    logic                  w_is_wb;
    logic                  w_to_cache;
    logic                  w_to_mem;
    logic                  w_multi_own;
    logic                  w_expire;
    logic [ERR_W-1:0]      w_err_set;

    // the requester never snoops its own request
    assign w_mask = ~(NUM_CORES'(1) << r_core);
    assign w_hit  = snoop_hit & w_mask;
    assign w_own  = snoop_owner & w_mask;

    assign w_is_upgr   = (r_type == BUS_UPGR);
    assign w_is_wb     = (r_type == BUS_WB);
    assign w_to_cache  = !w_is_upgr && !w_is_wb && (|w_own);
    assign w_to_mem    = !w_is_upgr && !w_is_wb && !(|w_own);
    assign w_multi_own = |(w_own & (w_own - NUM_CORES'(1)));

`ifdef COH_SEQ_TIMEOUT_EN
    seq_state_e r_state_d;
    logic       w_wd_en;
    logic       w_wd_clr;

    assign w_wd_en  = (r_state == S_MEM_REQ)  ||
                      (r_state == S_MEM_RESP) ||
                      (r_state == S_CACHE_DATA);
    assign w_wd_clr = (r_state != r_state_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_d <= S_IDLE;
        end else begin
            r_state_d <= r_state;
        end
    end

    coh_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (w_wd_en),
        .clear  (w_wd_clr),
        .expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_type       <= BUS_WB;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core       <= '0;
            r_busy       <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_fill_valid <= 1'b0;
            r_fill_data  <= '0;
            r_shared     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus_valid) begin
                        r_type      <= bus_type_e'(bus_type);
                        r_addr      <= bus_addr;
                        r_wdata     <= bus_wdata;
                        r_core      <= granted_core_id;
                        r_fill_data <= '0;
                        r_shared    <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SNOOP;
                    end
                end
                S_SNOOP: begin
                    r_shared <= (r_type == BUS_RD) && (|w_hit);
                    unique case (1'b1)
                        w_is_upgr: begin
                            r_fill_valid <= 1'b1;
                            r_state      <= S_FILL;
                        end
                        w_is_wb: begin
                            r_mem_valid <= 1'b1;
                            r_mem_wr    <= 1'b1;
                            r_state     <= S_MEM_WR;
                        end
                        w_to_cache: begin
                            r_state <= S_CACHE_DATA;
                        end
                        w_to_mem: begin
                            r_mem_valid <= 1'b1;
                            r_mem_wr    <= 1'b0;
                            r_state     <= S_MEM_REQ;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
                S_MEM_REQ: begin
                    if (w_expire) begin
                        r_mem_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (mem_req_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_MEM_RESP;
                    end
                end
                S_MEM_RESP: begin
                    if (w_expire) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (mem_resp_valid) begin
                        r_fill_data  <= mem_resp_rdata;
                        r_fill_valid <= 1'b1;
                        r_state      <= S_FILL;
                    end
                end
                S_CACHE_DATA: begin
                    if (w_expire) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (snoop_data_valid) begin
                        r_fill_data  <= snoop_data;
                        r_fill_valid <= 1'b1;
                        r_state      <= S_FILL;
                    end
                end
                S_MEM_WR: begin
                    if (mem_req_ready) begin
                        r_mem_valid  <= 1'b0;
                        r_mem_wr     <= 1'b0;
                        r_fill_valid <= 1'b1;
                        r_state      <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_fill_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_err_set[ERR_BUSY]        = bus_valid && (r_state != S_IDLE);
    assign w_err_set[ERR_MULTI_OWNER] = (r_state == S_SNOOP) && w_multi_own;
    assign w_err_set[ERR_TIMEOUT]     = w_expire;

    // a new error in the clearing cycle survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else begin
            r_err <= (err_clr ? '0 : r_err) | w_err_set;
        end
    end

    assign seq_busy      = r_busy;
    assign mem_req_valid = r_mem_valid;
    assign mem_req_write = r_mem_wr;
    assign mem_req_addr  = r_addr & LINE_MASK;
    assign mem_req_wdata = r_wdata;
    assign fill_valid    = r_fill_valid;
    assign fill_core_id  = r_core;
    assign fill_type     = r_type;
    assign fill_data     = r_fill_data;
    assign fill_shared   = r_shared;
    assign err_status    = r_err;

endmodule

// File: doc/coherency_mem_sequencer.md
COHERENCY_MEM_SEQUENCER -- requirements
Module: coherency_mem_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_CORES 4 (requesters); ADDR_WIDTH 64; LINE_BYTES 64; DATA_WIDTH LINE_BYTES*8; TIMEOUT_CYCLES 256 (watchdog limit).
REQ-002 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-003 Ports SHALL be (name dir width meaning):
- clk in 1: clock.
- rst_n in 1: async active-low reset.
- bus_valid in 1: arbiter broadcast valid.
- bus_type in 2: transaction type.
- bus_addr in ADDR_WIDTH: broadcast address.
- bus_wdata in DATA_WIDTH: writeback line from the granted cache.
- granted_core_id in 2: requester.
- snoop_hit in NUM_CORES: snooper holds the line.
- snoop_owner in NUM_CORES: snooper in M/O, will supply data.
- snoop_data_valid in 1: owner data strobe.
- snoop_data in DATA_WIDTH: owner data.
- seq_busy out 1: arbiter must not grant.
- mem_req_valid out 1; mem_req_write out 1; mem_req_addr out ADDR_WIDTH; mem_req_wdata out DATA_WIDTH; mem_req_ready in 1: memory request channel.
- mem_resp_valid in 1; mem_resp_rdata in DATA_WIDTH: memory read response.
- fill_valid out 1: completion pulse.
- fill_core_id out 2: completion target.
- fill_type out 2: echoed bus_type.
- fill_data out DATA_WIDTH: line data.
- fill_shared out 1: another cache retains a copy.
- err_status out 3: sticky errors.
- err_clr in 1: clears err_status.

Function
REQ-004 Bus types SHALL be: 2'b00 WB, 2'b01 RD, 2'b10 RDX, 2'b11 UPGR.
REQ-005 FSM states SHALL be IDLE, SNOOP, MEM_REQ, MEM_RESP, CACHE_DATA, MEM_WR and FILL.
REQ-006 In IDLE, bus_valid SHALL capture type, addr, wdata and core_id, then go to SNOOP; seq_busy SHALL be 1 in every state except IDLE.
REQ-007 In SNOOP, snoop_hit and snoop_owner SHALL be sampled with the requester bit masked, and the next state SHALL be:
- UPGR: FILL.
- WB: MEM_WR.
- RD/RDX with any owner bit: CACHE_DATA.
- Otherwise: MEM_REQ.
REQ-008 mem_req_addr SHALL equal the captured address with its low log2(LINE_BYTES) bits forced to 0.
REQ-009 In MEM_REQ, mem_req_valid=1 and mem_req_write=0 SHALL be driven; on mem_req_ready the FSM SHALL go to MEM_RESP.
REQ-010 In MEM_RESP, mem_resp_valid SHALL latch mem_resp_rdata into fill_data and the FSM SHALL go to FILL.
REQ-011 In MEM_WR, mem_req_valid=1, mem_req_write=1 and mem_req_wdata=captured wdata SHALL be driven; on mem_req_ready the FSM SHALL go to FILL.
REQ-012 In CACHE_DATA, snoop_data_valid SHALL latch snoop_data into fill_data and the FSM SHALL go to FILL; memory SHALL NOT be written, since ownership stays in the caches.
REQ-013 FILL SHALL last exactly one cycle with fill_valid=1, then return to IDLE; fill_data SHALL be 0 for UPGR and WB.
REQ-014 fill_shared SHALL be |masked snoop_hit for RD and SHALL be 0 for RDX, UPGR and WB.
REQ-015 mem_req_valid SHALL stay asserted, with stable fields, until mem_req_ready.
REQ-016 Minimum RD-from-memory latency SHALL be: bus_valid at T, mem_req_valid at T+2, fill_valid one cycle after mem_resp_valid.
REQ-017 bus_valid while not IDLE SHALL be ignored and SHALL set err_status[0].
REQ-018 More than one masked owner bit SHALL set err_status[1]; the sequencer SHALL proceed as normal.
REQ-019 err_status bits SHALL be sticky until err_clr=1; if err_clr coincides with a new error, the set SHALL win.

Reset
REQ-020 Reset SHALL force the FSM to IDLE and every output to 0.
REQ-021 Reset mid-transaction SHALL abort with no fill and no further memory request.

Configuration
REQ-022 With COH_SEQ_TIMEOUT_EN defined, a counter SHALL run in MEM_REQ, MEM_RESP and CACHE_DATA and clear on every state change.
REQ-023 With COH_SEQ_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES SHALL set err_status[2] and return the FSM to IDLE with no fill.
REQ-024 Without COH_SEQ_TIMEOUT_EN, there SHALL be no counter, err_status[2] SHALL be tied to 0, and waits SHALL be unbounded.

Structure
REQ-025 The shared package moesi_pkg SHALL hold the bus type encodings, the FSM state enum and the err_status bit indices.
REQ-026 The watchdog SHALL be sub-module coh_seq_watchdog (enable, clear, expire), instantiated only under COH_SEQ_TIMEOUT_EN.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- RD core1 addr 0x1047, no hits, memory latency 4 -> mem_req_addr 0x1040, fill_valid to core1 one cycle after resp, fill_shared 0.
- RD core0, snoop_hit 4'b0100, snoop_owner 4'b0100, snoop_data 0xAA.. -> no mem_req, fill_data 0xAA.., fill_shared 1.
- WB core2 addr 0x2000, wdata 0x55.., mem_req_ready held low 3 cycles -> request held stable, then write, then fill_valid with fill_data 0.
- UPGR core3 -> fill_valid at T+2, no memory traffic.
- bus_valid during MEM_RESP -> ignored, err_status 3'b001; err_clr -> 0.
- Timeout build, TIMEOUT_CYCLES 8, mem_req_ready never asserted -> err_status[2] after 8 cycles, FSM back in IDLE, no fill.
